// File: rtl/prog_mem_loader_if.sv
// Byte-stream receive side and program-memory write port of the loader.
// master = byte source / memory side, slave = loader.
interface prog_mem_loader_if #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [PC_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Loads program memory from a byte stream: length byte, then N words high byte first.
// Holds the CPU off for the whole load; all status/strobe outputs are registered.
module prog_mem_loader #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CMD_CNT    = 64
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    start,
    prog_mem_loader_if.slave        bus,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_DONE, S_ERR
    } state_t;

    state_t              state, state_nxt;
    logic [BYTE_W-1:0]   len_q;
    logic [BYTE_W-1:0]   hi_q;
    logic                xfer;
    logic                len_ok;
    logic                last_word;
    logic                rx_ready_nxt, we_nxt, hold_nxt, busy_nxt, done_nxt, err_nxt;

    assign xfer      = bus.rx_valid & bus.rx_ready;
    assign len_ok    = (bus.rx_data != '0) && (32'(bus.rx_data) <= CMD_CNT);
    assign last_word = (bus.mem_addr == PC_WIDTH'(len_q - 8'd1));

    // State register; outputs are registered from the decoded next state
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state        <= S_IDLE;
            bus.rx_ready <= 1'b0;
            bus.mem_we   <= 1'b0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.rx_ready <= rx_ready_nxt;
            bus.mem_we   <= we_nxt;
            cpu_hold     <= hold_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_LEN;
            S_LEN:  if (xfer)  state_nxt = len_ok ? S_HI : S_ERR;
            S_HI:   if (xfer)  state_nxt = S_LO;
            S_LO:   if (xfer)  state_nxt = S_WR;
            S_WR:   state_nxt = last_word ? S_DONE : S_HI;
            S_DONE: state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore decode of the state about to be entered
    always_comb begin
        rx_ready_nxt = 1'b0;
        we_nxt       = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        busy_nxt     = (state_nxt != S_IDLE);
        hold_nxt     = (state_nxt != S_IDLE);
        unique case (state_nxt)
            S_LEN, S_HI, S_LO: rx_ready_nxt = 1'b1;
            S_WR:              we_nxt       = 1'b1;
            S_DONE:            done_nxt     = 1'b1;
            S_ERR:             err_nxt      = 1'b1;
            default:           ;
        endcase
    end

    // Length, byte assembly and write address; address/data hold outside WR
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            len_q         <= '0;
            hi_q          <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            if (state == S_LEN && xfer) begin
                len_q <= bus.rx_data;
                if (len_ok) bus.mem_addr <= '0;
            end
            if (state == S_HI && xfer) hi_q <= bus.rx_data;
            if (state == S_LO && xfer) bus.mem_wdata <= DATA_WIDTH'({hi_q, bus.rx_data});
            if (state == S_WR && !last_word) bus.mem_addr <= bus.mem_addr + PC_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: a stream-level model predicts writes and
// done/err events; an independent monitor checks every strobe the DUT produces.
module tb_prog_mem_loader;
    localparam int unsigned PC_WIDTH   = 8;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned CMD_CNT    = 64;

    logic clk = 1'b0;
    logic res, start;
    logic cpu_hold, busy, done, err;

    always #5 clk = ~clk;

    prog_mem_loader_if #(.PC_WIDTH(PC_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bif();

    prog_mem_loader #(.PC_WIDTH(PC_WIDTH), .DATA_WIDTH(DATA_WIDTH), .CMD_CNT(CMD_CNT)) dut (
        .clk(clk), .res(res), .start(start), .bus(bif.slave),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    typedef struct { int addr; int data; } wr_t;

    int  checks = 0;
    int  errors = 0;
    wr_t wq[$];
    int  evq[$];          // 1 = done, 2 = err
    byte unsigned stream[$];
    int  cyc = 0;
    int  last_we_cyc = 0;
    wr_t mon_w;
    int  mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: length byte then N big-endian words written to 0..N-1, else error
    function automatic void model();
        int n = int'(stream[0]);
        if (n == 0 || n > int'(CMD_CNT)) begin
            evq.push_back(2);
        end else begin
            for (int i = 0; i < n; i++)
                wq.push_back('{addr: i, data: int'({stream[2*i+1], stream[2*i+2]})});
            evq.push_back(1);
        end
    endfunction

    function automatic void make_stream(input int n);
        stream.delete();
        stream.push_back(8'(n));
        if (n > 0 && n <= int'(CMD_CNT))
            for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom));
    endfunction

    // Monitor: every write strobe and status pulse must match the next expectation
    always @(negedge clk) begin
        if (res === 1'b0) begin
            if (bif.mem_we === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h required=none", bif.mem_addr, bif.mem_wdata);
                end else begin
                    mon_w = wq.pop_front();
                    check("write_addr", 32'(bif.mem_addr), mon_w.addr);
                    check("write_data", 32'(bif.mem_wdata), mon_w.data);
                    check("hold_during_write", 32'(cpu_hold), 1);
                end
                last_we_cyc = cyc;
            end
            if (done === 1'b1 || err === 1'b1) begin
                if (evq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event done=%0b err=%0b required=none", done, err);
                end else begin
                    mon_e = evq.pop_front();
                    check("event_kind", 32'({done, err}), (mon_e == 1) ? 32'h2 : 32'h1);
                    if (mon_e == 1) check("done_latency", 32'(cyc - last_we_cyc), 1);
                end
            end
        end
    end

    task automatic send_byte(input byte unsigned b, input int gap);
        int t = 0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (bif.rx_ready !== 1'b1 && t < 100);
        if (bif.rx_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout actual=%0b required=1", bif.rx_ready);
        end
        @(posedge clk);
        #1;
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'($urandom);
    endtask

    task automatic run_load(input int max_gap, input int n_send);
        @(negedge clk);
        check("idle_before_start", 32'(busy), 0);
        model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < n_send; i++)
            send_byte(stream[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    endtask

    task automatic wait_complete();
        int t = 0;
        while ((wq.size() != 0 || evq.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (wq.size() != 0 || evq.size() != 0) begin
            checks++; errors++;
            $display("FAIL completion_timeout pending_writes=%0d pending_events=%0d required=0", wq.size(), evq.size());
            wq.delete();
            evq.delete();
        end
        @(negedge clk);
        check("hold_released", 32'(cpu_hold), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int n;
        res = 1'b1; start = 1'b1;
        bif.rx_valid = 1'b1; bif.rx_data = 8'hA5;

        // Reset with valid/start asserted
        repeat (3) @(negedge clk);
        check("reset_flags", 32'({bif.rx_ready, bif.mem_we, cpu_hold, busy, done, err}), 0);
        check("reset_addr", 32'(bif.mem_addr), 0);
        check("reset_wdata", 32'(bif.mem_wdata), 0);
        start = 1'b0; bif.rx_valid = 1'b0;
        @(posedge clk); #1 res = 1'b0;
        @(negedge clk);
        check("rx_ready_idle", 32'(bif.rx_ready), 0);

        // Directed 3-word load, back-to-back then gapped
        stream = '{8'h03, 8'h49, 8'h03, 8'h4A, 8'h14, 8'h4B, 8'hF0};
        run_load(0, 7); wait_complete();
        run_load(4, 7); wait_complete();
        run_load(4, 7); wait_complete();

        // Illegal lengths
        stream = '{8'h00}; run_load(0, 1); wait_complete();
        stream = '{8'h41}; run_load(0, 1); wait_complete();
        stream = '{8'hFF}; run_load(2, 1); wait_complete();

        // Full-depth load
        make_stream(int'(CMD_CNT)); run_load(0, 1 + 2*int'(CMD_CNT)); wait_complete();

        // Reset after the second word of a 5-word load
        make_stream(5); run_load(1, 5);
        begin
            int t = 0;
            while (wq.size() > 3 && t < 100) begin @(posedge clk); t++; end
        end
        check("writes_before_abort", 32'(wq.size()), 3);
        #1 res = 1'b1;
        wq.delete(); evq.delete();
        @(negedge clk);
        check("abort_state", 32'({bif.rx_ready, cpu_hold, busy}), 0);
        @(posedge clk); #1 res = 1'b0;
        make_stream(5); run_load(0, 11); wait_complete();

        // Randomized loads, mixing in illegal lengths
        repeat (14) begin
            if ($urandom_range(4, 0) == 0) n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 65));
            else n = int'($urandom_range(12, 1));
            make_stream(n);
            run_load(4, stream.size());
            wait_complete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
